// File: rtl/gru_seq_ctrl_pkg.sv
// Shared definitions for the GRU sequencer and the GRU cell beside it.
// Holds the controller FSM state encoding and the default fixed-point
// word format, so controller and cell agree on word width.
package gru_seq_ctrl_pkg;

  // Default Q-format word: 8-bit signed, 5 fractional bits.
  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_FRACT_WIDTH = 5;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_OUTPUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCEPT = ST_ACCEPT,
    SETTLE = ST_SETTLE,
    OUTPUT = ST_OUTPUT
  } state_t;

endpackage

// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl: sequencer for a combinational 1x1 GRU cell.
// Runs one sequence of seq_len timesteps. Each timestep accepts one X sample
// on the x stream, holds X and the recurrent state h stable on the cell
// inputs for SETTLE_CYC cycles (multicycle path through the cell), captures
// the cell output as the new h and offers it on the y stream.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, seq_len,     begin a sequence (sampled in IDLE only); length and
//   h_init              initial state are latched on start
//   busy, done          not-idle flag, one-cycle end-of-sequence pulse
//   x_valid/x_ready/    input sample stream
//   x_data
//   cell_x, cell_h      registered drive to the cell X and h_in ports
//   cell_h_out          cell h_out
//   y_valid/y_ready/    output state stream; y_last marks the final h_t
//   y_data, y_last
module gru_seq_ctrl
  import gru_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FRACT_WIDTH = DEFAULT_FRACT_WIDTH,
  parameter int LEN_W       = 8,
  parameter int SETTLE_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      seq_len,
  input  logic [DATA_WIDTH-1:0] h_init,
  output logic                  busy,
  output logic                  done,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last
);

  localparam int WCNT_W = $clog2(SETTLE_CYC) + 1;

  // The controller only moves words; the fractional split matters to the
  // cell, but a nonsensical format or a zero settle time is still a bug.
  generate
    if (FRACT_WIDTH >= DATA_WIDTH || SETTLE_CYC < 1) begin : g_bad_params
      $error("gru_seq_ctrl: invalid FRACT_WIDTH or SETTLE_CYC");
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [LEN_W-1:0]      len_reg, idx_reg;
  logic [DATA_WIDTH-1:0] h_reg, x_reg, y_data_reg;
  logic [WCNT_W-1:0]     wcnt_reg;
  logic                  y_valid_reg, y_last_reg, done_reg;

  logic start_seq, start_empty, x_fire, settle_end, y_fire;

  // Next-state and handshake decode. x_ready depends on state only.
  always_comb begin
    state_next  = state_reg;
    start_seq   = 1'b0;
    start_empty = 1'b0;
    x_fire      = 1'b0;
    settle_end  = 1'b0;
    y_fire      = 1'b0;
    x_ready     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            start_seq  = 1'b1;
            state_next = ACCEPT;
          end else begin
            start_empty = 1'b1;
          end
        end
      end
      ACCEPT: begin
        x_ready = 1'b1;
        if (x_valid) begin
          x_fire     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (wcnt_reg == '0) begin
          settle_end = 1'b1;
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        if (y_ready) begin
          y_fire     = 1'b1;
          state_next = y_last_reg ? IDLE : ACCEPT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg     <= '0;
      idx_reg     <= '0;
      h_reg       <= '0;
      x_reg       <= '0;
      y_data_reg  <= '0;
      wcnt_reg    <= '0;
      y_valid_reg <= 1'b0;
      y_last_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // An empty sequence still reports completion so the caller never waits.
      done_reg <= start_empty | (y_fire & y_last_reg);

      if (start_seq) begin
        len_reg <= seq_len;
        h_reg   <= h_init;
        idx_reg <= '0;
      end

      // wcnt is loaded so the capture happens on the SETTLE_CYC-th SETTLE cycle.
      if (x_fire) begin
        x_reg    <= x_data;
        wcnt_reg <= WCNT_W'(SETTLE_CYC - 1);
      end else if (state_reg == SETTLE && wcnt_reg != '0) begin
        wcnt_reg <= wcnt_reg - WCNT_W'(1);
      end

      if (settle_end) begin
        h_reg       <= cell_h_out;
        y_data_reg  <= cell_h_out;
        y_valid_reg <= 1'b1;
        y_last_reg  <= (idx_reg == len_reg - LEN_W'(1));
      end

      if (y_fire) begin
        y_valid_reg <= 1'b0;
        y_last_reg  <= 1'b0;
        if (!y_last_reg) idx_reg <= idx_reg + LEN_W'(1);
      end
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign cell_x  = x_reg;
  assign cell_h  = h_reg;
  assign y_valid = y_valid_reg;
  assign y_data  = y_data_reg;
  assign y_last  = y_last_reg;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Bench for gru_seq_ctrl with a stub cell (h_out = X + h, 8-bit wrap).
// The reference model tracks each sequence as h_t = h_{t-1} + X_t and knows
// the fixed timestep shape: accept, SETTLE_CYC settle cycles, output.
module tb_gru_seq_ctrl;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [LW-1:0] seq_len;
  logic [DW-1:0] h_init, x_data, cell_x, cell_h, cell_h_out, y_data;
  logic          x_valid, x_ready, y_valid, y_ready, y_last;

  always #5 clk = ~clk;

  // Stub GRU cell.
  assign cell_h_out = cell_x + cell_h;

  gru_seq_ctrl #(
    .DATA_WIDTH(DW), .FRACT_WIDTH(5), .LEN_W(LW), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .h_init(h_init),
    .busy(busy), .done(done), .x_valid(x_valid), .x_ready(x_ready),
    .x_data(x_data), .cell_x(cell_x), .cell_h(cell_h),
    .cell_h_out(cell_h_out), .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .y_last(y_last)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int seq_no   = 0;
  logic [DW-1:0] x_tab [16];
  logic [DW-1:0] got_q [$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_x();
    x_valid = 1'($urandom);
    x_data  = 8'($urandom);
  endtask

  // One complete sequence driven from x_tab. Stall length per output is drawn
  // from [st_lo, st_hi]; xv_pct is the chance x_valid is offered per cycle.
  task automatic run_seq(input logic [DW-1:0] h0, input int len,
                         input int st_lo, input int st_hi, input int xv_pct,
                         input bit mid_start);
    logic [DW-1:0] exp_h;
    int            waits, stall;
    bit            last;
    got_q.delete();
    seq_no++;
    exp_h   = h0;
    start   = 1'b1;
    seq_len = 8'(len);
    h_init  = h0;
    junk_x();
    step();
    start   = 1'b0;
    seq_len = 8'($urandom);
    h_init  = 8'($urandom);
    check_val("start_busy", busy, 1);
    check_val("start_cell_h", cell_h, h0);
    for (int t = 0; t < len; t++) begin
      last  = (t == len - 1);
      waits = 0;
      // ACCEPT: offer X with random gaps; forced after 20 idle cycles.
      forever begin
        check_val("accept_x_ready", x_ready, 1);
        if (waits >= 20 || $urandom_range(99) < xv_pct) begin
          x_valid = 1'b1;
          x_data  = x_tab[t];
          step();
          break;
        end
        x_valid = 1'b0;
        x_data  = 8'($urandom);
        step();
        waits++;
      end
      // SETTLE: inputs to the cell held, nothing accepted, no output yet.
      for (int s = 0; s < SC; s++) begin
        check_val("settle_x_ready", x_ready, 0);
        check_val("settle_y_valid", y_valid, 0);
        check_val("settle_cell_x", cell_x, x_tab[t]);
        check_val("settle_cell_h", cell_h, exp_h);
        if (mid_start && t == 1 && s == 0) begin
          start   = 1'b1;
          seq_len = 8'd5;
          h_init  = 8'h7F;
        end
        junk_x();
        step();
        start = 1'b0;
      end
      exp_h = exp_h + x_tab[t];
      // OUTPUT: first cycle with y_valid, then optional backpressure.
      check_val("out_y_valid", y_valid, 1);
      check_val("out_y_data", y_data, exp_h);
      check_val("out_y_last", y_last, last);
      check_val("out_x_ready", x_ready, 0);
      stall = $urandom_range(st_hi, st_lo);
      for (int k = 0; k < stall; k++) begin
        y_ready = 1'b0;
        junk_x();
        step();
        check_val("stall_y_valid", y_valid, 1);
        check_val("stall_y_data", y_data, exp_h);
        check_val("stall_y_last", y_last, last);
        check_val("stall_x_ready", x_ready, 0);
      end
      got_q.push_back(y_data);
      $display("seq %0d step %0d: x=0x%02h y_data=0x%02h y_last=%0b stall=%0d",
               seq_no, t, x_tab[t], y_data, y_last, stall);
      y_ready = 1'b1;
      junk_x();
      step();
      y_ready = 1'b0;
      check_val("post_y_valid", y_valid, 0);
      if (last) begin
        check_val("end_done", done, 1);
        check_val("end_busy", busy, 0);
        junk_x();
        step();
        check_val("end_done_clear", done, 0);
      end else begin
        check_val("mid_done", done, 0);
      end
    end
    x_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seq_len = '0; h_init = '0;
    x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    step();
    step();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_x_ready", x_ready, 0);
    check_val("rst_y_valid", y_valid, 0);
    check_val("rst_y_last", y_last, 0);
    check_val("rst_y_data", y_data, 0);
    check_val("rst_cell_x", cell_x, 0);
    check_val("rst_cell_h", cell_h, 0);
    rst = 1'b0;
    step();

    // Basic three-step sequence, no stalls.
    x_tab[0] = 8'h01; x_tab[1] = 8'h02; x_tab[2] = 8'h03;
    run_seq(8'h10, 3, 0, 0, 100, 1'b0);
    check_val("t1_count", got_q.size(), 3);
    check_val("t1_y0", got_q[0], 8'h11);
    check_val("t1_y1", got_q[1], 8'h13);
    check_val("t1_y2", got_q[2], 8'h16);

    // Ten-cycle backpressure on every output.
    run_seq(8'h10, 3, 10, 10, 100, 1'b0);
    check_val("t3_y0", got_q[0], 8'h11);
    check_val("t3_y1", got_q[1], 8'h13);
    check_val("t3_y2", got_q[2], 8'h16);

    // Empty sequence.
    start = 1'b1; seq_len = 8'd0; h_init = 8'h55;
    step();
    start = 1'b0;
    check_val("t4_done", done, 1);
    check_val("t4_busy", busy, 0);
    check_val("t4_y_valid", y_valid, 0);
    check_val("t4_cell_h_kept", cell_h, 8'h16);
    step();
    check_val("t4_done_clear", done, 0);
    check_val("t4_busy_after", busy, 0);

    // start while busy is ignored; then signed wrap 0x7F + 1.
    run_seq(8'h10, 3, 0, 1, 70, 1'b1);
    check_val("t5_count", got_q.size(), 3);
    check_val("t5_y2", got_q[2], 8'h16);
    x_tab[0] = 8'h01;
    run_seq(8'h7F, 1, 0, 0, 100, 1'b0);
    check_val("t5_wrap", got_q[0], 8'h80);

    // Reset during SETTLE of timestep 2.
    start = 1'b1; seq_len = 8'd3; h_init = 8'h10;
    step();
    start = 1'b0;
    x_valid = 1'b1; x_data = 8'h01;
    step();
    x_valid = 1'b0;
    step();
    step();
    check_val("t6_y0", y_data, 8'h11);
    y_ready = 1'b1;
    step();
    y_ready = 1'b0;
    x_valid = 1'b1; x_data = 8'h02;
    step();
    x_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_busy", busy, 0);
    check_val("t6_done", done, 0);
    check_val("t6_x_ready", x_ready, 0);
    check_val("t6_y_valid", y_valid, 0);
    check_val("t6_y_last", y_last, 0);
    check_val("t6_y_data", y_data, 0);
    check_val("t6_cell_x", cell_x, 0);
    check_val("t6_cell_h", cell_h, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t6_no_done", done, 0);
      check_val("t6_idle", busy, 0);
    end
    x_tab[0] = 8'h05; x_tab[1] = 8'h06;
    run_seq(8'h20, 2, 0, 1, 100, 1'b0);
    check_val("t6_new_y0", got_q[0], 8'h25);
    check_val("t6_new_y1", got_q[1], 8'h2B);

    // Randomized sequences against the running-sum model.
    for (int r = 0; r < 25; r++) begin
      int len;
      len = $urandom_range(8, 1);
      for (int i = 0; i < len; i++) x_tab[i] = 8'($urandom);
      run_seq(8'($urandom), len, 0, 3, $urandom_range(100, 30),
              1'($urandom));
      check_val("rand_count", got_q.size(), len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
